// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W      = 64;
    localparam int INSTR_W     = 32;
    localparam int INSTR_ALIGN = 4;
    localparam int ALIGN_BITS  = $clog2(INSTR_ALIGN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    // An address is fetchable only if it lands on an instruction boundary.
    function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
        return addr[ALIGN_BITS-1:0] == '0;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory and decode-side signals of the fetch unit.
interface inst_fetch_if;
    import fetch_pkg::*;

    logic               im_req;
    logic [ADDR_W-1:0]  im_addr;
    logic               im_ack;
    logic [INSTR_W-1:0] im_data;

    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic               if_misalign;

    // Fetch unit side.
    modport master (
        output im_req, im_addr,
        input  im_ack, im_data,
        output if_valid, if_instr, if_pc, if_misalign,
        input  if_ready
    );

    // Memory / decode side.
    modport slave (
        input  im_req, im_addr,
        output im_ack, im_data,
        input  if_valid, if_instr, if_pc, if_misalign,
        output if_ready
    );

endinterface

// File: rtl/if_out_reg.sv
// Decode-side holding register: keeps the presented instruction stable.
module if_out_reg
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               misalign_in,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_misalign
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               misalign_q, misalign_d;

    // Clear wins over load; otherwise hold.
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (clear) begin
            instr_d    = '0;
            pc_d       = '0;
            misalign_d = 1'b0;
        end else if (load) begin
            instr_d    = instr_in;
            pc_d       = pc_in;
            misalign_d = misalign_in;
        end
    end

    // Register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= '0;
            pc_q       <= '0;
            misalign_q <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign if_instr    = instr_q;
    assign if_pc       = pc_q;
    assign if_misalign = misalign_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: samples the PC, fetches from instruction memory
// and presents one instruction at a time to decode.
//
// state | meaning
// IDLE  | ready to sample pc_addr
// WAIT  | request outstanding, result wanted
// HOLD  | instruction presented to decode, waiting for handshake
// DROP  | request outstanding after a flush, result discarded
module inst_fetch
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_take,
    input  logic              flush,
    inst_fetch_if.master      bus
);

    fetch_state_e       state_q, state_d;
    logic               im_req_q, im_req_d;
    logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               if_valid_q, if_valid_d;

    logic               take;
    logic               out_load;
    logic               out_clear;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_misalign;

    // Sampling is decided in the same cycle so the PC can step while HOLD
    // hands off, giving back-to-back fetches without a bubble.
    always_comb take = !flush && (state_q == IDLE || (state_q == HOLD && bus.if_ready));

    assign pc_take = take && !rst;

    // Next-state, request and holding-register control.
    always_comb begin
        state_d      = state_q;
        im_req_d     = im_req_q;
        im_addr_d    = im_addr_q;
        req_pc_d     = req_pc_q;
        if_valid_d   = if_valid_q;
        out_load     = 1'b0;
        out_clear    = 1'b0;
        out_instr    = '0;
        out_pc       = req_pc_q;
        out_misalign = 1'b0;

        case (state_q)
            IDLE: begin
            end
            WAIT: begin
                if (bus.im_ack) begin
                    im_req_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = HOLD;
                        if_valid_d = 1'b1;
                        out_load   = 1'b1;
                        out_instr  = bus.im_data;
                        out_pc     = req_pc_q;
                    end
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.im_ack) begin
                    im_req_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d    = IDLE;
                    if_valid_d = 1'b0;
                    out_clear  = 1'b1;
                end else if (bus.if_ready) begin
                    if_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A sample from IDLE or a completed HOLD handshake starts the next fetch.
        if (take) begin
            if (is_aligned(pc_addr)) begin
                state_d   = WAIT;
                im_req_d  = 1'b1;
                im_addr_d = pc_addr;
                req_pc_d  = pc_addr;
            end else begin
                state_d      = HOLD;
                if_valid_d   = 1'b1;
                out_load     = 1'b1;
                out_instr    = '0;
                out_pc       = pc_addr;
                out_misalign = 1'b1;
            end
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            im_req_q   <= 1'b0;
            im_addr_q  <= '0;
            req_pc_q   <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            im_req_q   <= im_req_d;
            im_addr_q  <= im_addr_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    if_out_reg u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (out_load),
        .clear       (out_clear),
        .instr_in    (out_instr),
        .pc_in       (out_pc),
        .misalign_in (out_misalign),
        .if_instr    (bus.if_instr),
        .if_pc       (bus.if_pc),
        .if_misalign (bus.if_misalign)
    );

    assign bus.im_req   = im_req_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.if_valid = if_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized
// run checked against a fetch-stream reference model.
module tb_inst_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_addr;
    logic        pc_take;
    logic        flush;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk     (clk),
        .rst     (rst),
        .pc_addr (pc_addr),
        .pc_take (pc_take),
        .flush   (flush),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model controls
    int          lat_fixed = 1;
    int          lat_max   = 4;
    bit          fixed_en  = 1'b0;
    logic [31:0] fixed_data = 32'h0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: answers each request after 1..N cycles, reset by rst.
    bit mem_busy = 1'b0;
    int mem_cnt  = 0;
    always begin : mem_model
        logic r;
        @(posedge clk);
        r = rst;
        #1;
        if (r) begin
            bus.im_ack = 1'b0;
            mem_busy   = 1'b0;
        end else begin
            if (bus.im_ack) begin
                bus.im_ack = 1'b0;
                mem_busy   = 1'b0;
            end
            if (bus.im_req && !mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = (lat_fixed != 0) ? lat_fixed - 1 : int'($urandom_range(lat_max - 1, 0));
            end
            if (mem_busy && !bus.im_ack) begin
                if (mem_cnt == 0) begin
                    bus.im_ack  = 1'b1;
                    bus.im_data = fixed_en ? fixed_data : mem_word(bus.im_addr);
                end else begin
                    mem_cnt--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release ("cycle 1").
    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.if_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.if_ready = 1'b1;
        pc_addr = 64'h104;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({pc_take, bus.im_req, bus.if_valid, bus.if_misalign} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got take/req/valid/mis=%b expected 0000",
                     {pc_take, bus.im_req, bus.if_valid, bus.if_misalign});
        end
        checks++;
        if ({bus.im_addr, bus.if_pc, bus.if_instr} !== 160'h0) begin
            errors++;
            $display("FAIL reset_data: got im_addr=%h if_pc=%h if_instr=%h expected all 0",
                     bus.im_addr, bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_first_fetch();
        lat_fixed = 1;
        fixed_en = 1'b1;
        fixed_data = 32'h8B020020;
        do_reset();
        pc_addr = 64'h0;
        @(negedge clk);
        checks++;
        if (pc_take !== 1'b1) begin
            errors++;
            $display("FAIL first_take: got pc_take=%b expected 1 in cycle 1", pc_take);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.im_req, bus.im_addr, pc_take} !== {1'b1, 64'h0, 1'b0}) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h take=%b expected 1 0 0",
                     bus.im_req, bus.im_addr, pc_take);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.if_misalign, bus.im_req} !==
            {1'b1, 32'h8B020020, 64'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL first_data: got valid=%b instr=%h pc=%h mis=%b req=%b expected 1 8b020020 0 0 0",
                     bus.if_valid, bus.if_instr, bus.if_pc, bus.if_misalign, bus.im_req);
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_stream();
        int          take_cyc[$];
        int          hs_cyc[$];
        logic [63:0] hs_pc[$];
        bit          took;
        lat_fixed = 1;
        do_reset();
        pc_addr = 64'h0;
        bus.if_ready = 1'b1;
        took = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                tick();
                if (took) pc_addr = pc_addr + 64'd4;
            end
            @(negedge clk);
            took = pc_take;
            if (pc_take) take_cyc.push_back(c);
            if (bus.if_valid && bus.if_ready) begin
                checks++;
                if ({bus.if_pc, bus.if_instr} !== {64'(4 * hs_pc.size()), mem_word(64'(4 * hs_pc.size()))}) begin
                    errors++;
                    $display("FAIL stream_data: got pc=%h instr=%h expected pc=%h",
                             bus.if_pc, bus.if_instr, 64'(4 * hs_pc.size()));
                end
                hs_pc.push_back(bus.if_pc);
                hs_cyc.push_back(c);
            end
        end
        checks++;
        if (hs_cyc.size() != 3 || take_cyc.size() != 4) begin
            errors++;
            $display("FAIL stream_count: got %0d instrs %0d takes expected 3 and 4",
                     hs_cyc.size(), take_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hs_cyc[i] != 3 + 2 * i || take_cyc[i] != 1 + 2 * i) begin
                    errors++;
                    $display("FAIL stream_rate: instr %0d at cycle %0d take at %0d expected %0d and %0d",
                             i, hs_cyc[i], take_cyc[i], 3 + 2 * i, 1 + 2 * i);
                end
            end
        end
    endtask

    task automatic test_flush_drop();
        lat_fixed = 5;
        do_reset();
        pc_addr = 64'h10;
        bus.if_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_take !== 1'b1) begin
            errors++;
            $display("FAIL drop_take0: got pc_take=%b expected 1", pc_take);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.im_req, bus.im_addr} !== {1'b1, 64'h10}) begin
            errors++;
            $display("FAIL drop_req: got req=%b addr=%h expected 1 10", bus.im_req, bus.im_addr);
        end
        tick();
        flush = 1'b1;
        pc_addr = 64'h40;
        @(negedge clk);
        checks++;
        if (pc_take !== 1'b0) begin
            errors++;
            $display("FAIL drop_take_flush: got pc_take=%b expected 0", pc_take);
        end
        for (int c = 4; c <= 6; c++) begin
            tick();
            flush = (c == 5);
            @(negedge clk);
            checks++;
            if ({bus.im_req, bus.if_valid, pc_take} !== 3'b100) begin
                errors++;
                $display("FAIL drop_wait c%0d: got req/valid/take=%b expected 100",
                         c, {bus.im_req, bus.if_valid, pc_take});
            end
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.im_req, bus.if_valid, pc_take} !== 3'b001) begin
            errors++;
            $display("FAIL drop_done: got req/valid/take=%b expected 001",
                     {bus.im_req, bus.if_valid, pc_take});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.im_req, bus.im_addr, bus.if_valid} !== {1'b1, 64'h40, 1'b0}) begin
            errors++;
            $display("FAIL drop_redirect: got req=%b addr=%h valid=%b expected 1 40 0",
                     bus.im_req, bus.im_addr, bus.if_valid);
        end
    endtask

    task automatic test_stall();
        lat_fixed = 1;
        do_reset();
        pc_addr = 64'h20;
        bus.if_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (pc_take !== 1'b1) begin
            errors++;
            $display("FAIL stall_take0: got pc_take=%b expected 1", pc_take);
        end
        tick();
        pc_addr = 64'h24;
        for (int c = 3; c <= 7; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({bus.if_valid, bus.if_pc, bus.if_instr, pc_take, bus.im_req} !==
                {1'b1, 64'h20, mem_word(64'h20), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold c%0d: got valid=%b pc=%h instr=%h take=%b req=%b expected 1 20 %h 0 0",
                         c, bus.if_valid, bus.if_pc, bus.if_instr, pc_take, bus.im_req, mem_word(64'h20));
            end
        end
        tick();
        bus.if_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_take !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got pc_take=%b expected 1", pc_take);
        end
        tick();
        bus.if_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.im_req, bus.im_addr, bus.if_valid} !== {1'b1, 64'h24, 1'b0}) begin
            errors++;
            $display("FAIL stall_next: got req=%b addr=%h valid=%b expected 1 24 0",
                     bus.im_req, bus.im_addr, bus.if_valid);
        end
    endtask

    task automatic test_misalign();
        lat_fixed = 1;
        do_reset();
        pc_addr = 64'h6;
        bus.if_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (pc_take !== 1'b1) begin
            errors++;
            $display("FAIL mis_take: got pc_take=%b expected 1", pc_take);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.im_req, bus.if_valid, bus.if_misalign, bus.if_instr, bus.if_pc} !==
            {1'b0, 1'b1, 1'b1, 32'h0, 64'h6}) begin
            errors++;
            $display("FAIL mis_out: got req=%b valid=%b mis=%b instr=%h pc=%h expected 0 1 1 0 6",
                     bus.im_req, bus.if_valid, bus.if_misalign, bus.if_instr, bus.if_pc);
        end
        tick();
        flush = 1'b1;
        bus.if_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_take !== 1'b0) begin
            errors++;
            $display("FAIL mis_flush_take: got pc_take=%b expected 0", pc_take);
        end
        tick();
        flush = 1'b0;
        bus.if_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.if_valid, bus.if_misalign, bus.im_req} !== 3'b000) begin
            errors++;
            $display("FAIL mis_flushed: got valid/mis/req=%b expected 000",
                     {bus.if_valid, bus.if_misalign, bus.im_req});
        end
    endtask

    task automatic test_reset_mid();
        lat_fixed = 1;
        do_reset();
        pc_addr = 64'h80;
        bus.if_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_take !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_take: got pc_take=%b expected 1", pc_take);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.im_req, bus.im_addr, pc_take} !== {1'b1, 64'h80, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_wait: got req=%b addr=%h take=%b expected 1 80 0",
                     bus.im_req, bus.im_addr, pc_take);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.if_valid, bus.im_req, bus.im_addr, bus.if_pc} !== {1'b0, 1'b0, 64'h0, 64'h0}) begin
            errors++;
            $display("FAIL rstmid_after: got valid=%b req=%b addr=%h pc=%h expected 0 0 0 0",
                     bus.if_valid, bus.im_req, bus.im_addr, bus.if_pc);
        end
    endtask

    // Reference model: every pc_take starts one fetch; decode must see the
    // fetched PCs in order, each with memory contents (or zero + misalign),
    // and a flush throws away whatever has not been handed over.
    task automatic test_random();
        logic [63:0] exp_q[$];
        logic [63:0] req_pc;
        logic [31:0] exp_instr;
        bit          took;
        bit          want_req;
        int          hs;
        lat_fixed = 0;
        lat_max = 4;
        do_reset();
        pc_addr = 64'h0;
        bus.if_ready = 1'b1;
        took = 1'b0;
        want_req = 1'b0;
        req_pc = 64'h0;
        hs = 0;
        for (int c = 1; c <= 600; c++) begin
            if (c > 1) begin
                tick();
                if (took) pc_addr = pc_addr + (($urandom_range(15, 0) == 0) ? 64'd2 : 64'd4);
                flush = ($urandom_range(11, 0) == 0);
                if (flush)
                    pc_addr = ({$urandom, $urandom} & ~64'h3) | (($urandom_range(7, 0) == 0) ? 64'h2 : 64'h0);
                bus.if_ready = ($urandom_range(9, 0) < 7);
            end
            @(negedge clk);
            if (want_req || bus.im_req) begin
                checks++;
                if ({bus.im_req, bus.im_addr} !== {1'b1, req_pc}) begin
                    errors++;
                    $display("FAIL rnd_req c%0d: got req=%b addr=%h expected 1 %h",
                             c, bus.im_req, bus.im_addr, req_pc);
                end
            end
            want_req = 1'b0;
            if (bus.if_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_valid c%0d: got if_valid=1 pc=%h expected no instruction", c, bus.if_pc);
                end else begin
                    exp_instr = is_aligned(exp_q[0]) ? mem_word(exp_q[0]) : 32'h0;
                    if ({bus.if_pc, bus.if_instr, bus.if_misalign} !== {exp_q[0], exp_instr, !is_aligned(exp_q[0])}) begin
                        errors++;
                        $display("FAIL rnd_data c%0d: got pc=%h instr=%h mis=%b expected %h %h %b",
                                 c, bus.if_pc, bus.if_instr, bus.if_misalign,
                                 exp_q[0], exp_instr, !is_aligned(exp_q[0]));
                    end
                    if (bus.if_ready && !flush) begin
                        void'(exp_q.pop_front());
                        hs++;
                    end
                end
            end
            if (flush) begin
                checks++;
                if (pc_take !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_take_flush c%0d: got pc_take=%b expected 0", c, pc_take);
                end
                exp_q.delete();
            end
            if (pc_take) begin
                exp_q.push_back(pc_addr);
                checks++;
                if (exp_q.size() > 1) begin
                    errors++;
                    $display("FAIL rnd_take_busy c%0d: got %0d fetches in flight expected 1", c, exp_q.size());
                end
                if (is_aligned(pc_addr)) begin
                    want_req = 1'b1;
                    req_pc = pc_addr;
                end
            end
            took = pc_take;
        end
        flush = 1'b0;
        checks++;
        if (hs < 20) begin
            errors++;
            $display("FAIL rnd_progress: got %0d instructions expected at least 20", hs);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        pc_addr = 64'h0;
        bus.if_ready = 1'b0;
        bus.im_ack = 1'b0;
        bus.im_data = 32'h0;
        test_reset();
        test_first_fetch();
        test_stream();
        test_flush_drop();
        test_stall();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL use exactly one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pc_addr  input  64  current fetch address, driven by the PC register.
REQ-005 pc_take  output  1  one-cycle pulse when pc_addr is sampled; the PC/next-PC stage advances only on this pulse.
REQ-006 flush  input  1  redirect (taken branch/exception); discards in-flight and held fetches.
REQ-007 im_req  output  1  instruction-memory request.
REQ-008 im_addr  output  64  instruction-memory address.
REQ-009 im_ack  input  1  memory response valid; latency 1..N cycles.
REQ-010 im_data  input  32  instruction word, valid when im_ack=1.
REQ-011 if_valid  output  1  instruction available to decode.
REQ-012 if_ready  input  1  decode accepts the instruction.
REQ-013 if_instr  output  32  fetched instruction.
REQ-014 if_pc  output  64  address of if_instr.
REQ-015 if_misalign  output  1  qualifies if_valid; set when if_pc[1:0]!=0.

Function
REQ-016 The FSM SHALL have 4 states: IDLE, WAIT, HOLD, DROP; the reset state SHALL be IDLE.
REQ-017 IDLE: if flush=0, sample pc_addr and pulse pc_take.
- Aligned address: latch into req_pc and im_addr, set im_req=1 next cycle, go to WAIT.
- Misaligned address: no request; next cycle if_valid=1, if_misalign=1, if_instr=0, if_pc=pc_addr; go to HOLD.
REQ-018 WAIT: hold im_req=1 and keep im_addr stable until im_ack.
- im_ack=1, flush=0: next cycle if_instr=im_data, if_pc=req_pc, if_valid=1, im_req=0; go to HOLD.
- im_ack=1, flush=1: discard the data, im_req=0; go to IDLE.
- flush=1, im_ack=0: go to DROP.
REQ-019 DROP: keep im_req=1 until im_ack; discard im_data on im_ack, drop im_req, go to IDLE; flush in DROP SHALL have no further effect.
REQ-020 HOLD: if_valid, if_instr, if_pc and if_misalign SHALL stay stable until handshake or flush.
REQ-021 HOLD with if_ready=1, flush=0: handshake completes; in the same cycle sample pc_addr, pulse pc_take and proceed as from IDLE (back-to-back fetch, no bubble).
REQ-022 HOLD with flush=1: clear if_valid next cycle and go to IDLE, regardless of if_ready.
REQ-023 Throughput SHALL be one instruction per (memory latency + 1) cycles with decode always ready.
REQ-024 pc_take SHALL never assert in WAIT or DROP, and SHALL never assert in a cycle where flush=1.
REQ-025 im_ack outside WAIT/DROP SHALL be ignored.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL go to IDLE and clear im_req, pc_take, if_valid and if_misalign; im_addr, if_pc and if_instr SHALL be cleared to 0.
REQ-027 rst SHALL take priority over flush, im_ack and if_ready; reset mid-request SHALL abandon the transaction; the memory is reset by the same rst.

Structure
REQ-028 A shared package fetch_pkg SHALL hold the FSM state enum, ADDR_W=64, INSTR_W=32 and INSTR_ALIGN=4.
REQ-029 One sub-module if_out_reg SHALL implement the decode-side holding register: if_instr, if_pc, if_misalign, with load and clear controls.

Verification
REQ-030 Reset then pc_addr=0x0, 1-cycle im_ack with im_data=0x8B020020 -> pc_take at cycle 1, im_addr=0x0, if_valid with if_instr=0x8B020020, if_pc=0x0.
REQ-031 Decode ready, latency 1, PC stepping by 4 -> if_pc sequence 0x0, 0x4, 0x8, one instruction every 2 cycles, pc_take once per instruction.
REQ-032 flush one cycle after the request to 0x10, im_ack 3 cycles later -> DROP entered, data discarded, no if_valid, next pc_take fetches the redirect address 0x40.
REQ-033 if_ready=0 for 5 cycles in HOLD -> if_instr/if_pc stable, no pc_take, im_req=0 throughout.
REQ-034 pc_addr=0x6 -> no im_req, if_valid=1, if_misalign=1, if_instr=0, if_pc=0x6.
REQ-035 rst asserted in WAIT with im_ack arriving the same cycle -> IDLE, if_valid=0, im_req=0 next cycle.
